edge_binarize: RTL and testbench
================================

EDGE_BINARIZE -- requirements
Module: edge_binarize

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning per-channel pixel width.
REQ-002 SHALL have parameter H_RES, default 640, meaning active pixels per line.
REQ-003 SHALL have parameter V_RES, default 480, meaning active lines per frame.
REQ-004 SHALL have parameter BORDER, default 2, meaning leading columns/rows forced to non-edge.
REQ-005 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-006 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have ports i_vsync, i_hsync, i_de  input  1 each  sync/data-enable from the Sobel gradient stage.
REQ-008 SHALL have ports i_r_data, i_g_data, i_b_data  input  WIDTH each  per-channel gradient magnitude.
REQ-009 SHALL have port i_thresh  input  WIDTH  edge threshold, sampled per frame.
REQ-010 SHALL have port i_invert  input  1  1 = black edges on white background, sampled per frame.
REQ-011 SHALL have ports o_vsync, o_hsync, o_de  output  1 each  syncs delayed to match data.
REQ-012 SHALL have ports o_r_data, o_g_data, o_b_data  output  WIDTH each  binarized pixel, all three equal.
REQ-013 SHALL have port o_edge_count  output  $clog2(H_RES*V_RES+1)  edge pixels counted in the last completed frame.
REQ-014 SHALL have port o_count_valid  output  1  one-cycle pulse when o_edge_count updates.

Function
REQ-015 SHALL detect frame start as i_vsync rising edge (registered i_vsync 0, current 1).
REQ-016 SHALL latch i_thresh and i_invert into frame registers only at frame start; mid-frame changes have no effect until the next frame start.
REQ-017 SHALL keep column counter x: +1 per cycle with i_de=1, saturating at H_RES-1; cleared to 0 on i_de falling edge.
REQ-018 SHALL keep row counter y: +1 on each i_de falling edge, saturating at V_RES-1; cleared to 0 at frame start (clear wins over increment in the same cycle).
REQ-019 SHALL compute stage 1 (registered): gray = (r + 2*g + b) >> 2 using a WIDTH+2-bit sum, result WIDTH bits, no overflow; x/y border flag registered alongside.
REQ-020 SHALL compute stage 2 (registered): edge = (gray >= latched threshold) AND NOT border, where border = (x < BORDER) OR (y < BORDER) for the pixel's coordinates.
REQ-021 SHALL drive each output channel to all-ones when (edge XOR latched invert)=1, else all-zeros, when stage-2 de=1; all-zeros when stage-2 de=0.
REQ-022 SHALL have fixed latency 2 clocks from input pixel to output pixel; o_vsync/o_hsync/o_de SHALL be the inputs delayed exactly 2 clocks.
REQ-023 SHALL advance the pipeline every clock, independent of i_de.
REQ-024 SHALL count stage-2 pixels with de=1 and edge=1 (before inversion) in a frame counter saturating at H_RES*V_RES.
REQ-025 SHALL at frame start copy the frame counter to o_edge_count, pulse o_count_valid for exactly one cycle, and reload the counter with 1 if a counted pixel exits stage 2 that same cycle, else 0.
REQ-026 SHALL treat threshold 0 as all non-border pixels being edges; threshold all-ones as only gray = all-ones pixels being edges.

Reset
REQ-027 SHALL on rstn=0 asynchronously clear all outputs, pipeline registers, x, y, frame counter, latched threshold (0) and latched invert (0).
REQ-028 SHALL resume on rstn deassertion with a first o_count_valid only at the next frame start, reporting edges seen since reset.
REQ-029 SHALL tolerate reset asserted mid-frame: no o_count_valid pulse, outputs 0 within the reset assertion.

Verification
REQ-030 Thresh: i_thresh=100 latched, pixels r=g=b=99 then 100 at x=5,y=5 -> outputs 0 then 255 (WIDTH=8), 2 cycles after input.
REQ-031 Border: all pixels r=g=b=255, i_thresh=0 -> x<2 or y<2 output 0, others 255; frame count reported = (640-2)*(480-2)=304964.
REQ-032 Invert: i_invert=1 latched, same frame as REQ-031 -> border pixels 255, interior 0; o_edge_count still 304964.
REQ-033 Mid-frame change: i_thresh 100->200 at line 240 -> whole frame uses 100; next frame uses 200.
REQ-034 Weighting: r=0,g=255,b=0 -> gray=127; i_thresh=127 -> 255 out, i_thresh=128 -> 0 out.
REQ-035 Reset: rstn low for 3 cycles at line 100 -> outputs/syncs 0 immediately, no o_count_valid; next frame start pulses o_count_valid once with count of post-reset edges.

Source files
------------

// File: rtl/edge_binarize.sv
// Gradient-to-binary edge stage: gray conversion, per-frame threshold,
// border masking, optional inversion and per-frame edge pixel count.
module edge_binarize #(
    parameter int WIDTH  = 8,
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int BORDER = 2
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              i_vsync,
    input  logic                              i_hsync,
    input  logic                              i_de,
    input  logic [WIDTH-1:0]                  i_r_data,
    input  logic [WIDTH-1:0]                  i_g_data,
    input  logic [WIDTH-1:0]                  i_b_data,
    input  logic [WIDTH-1:0]                  i_thresh,
    input  logic                              i_invert,
    output logic                              o_vsync,
    output logic                              o_hsync,
    output logic                              o_de,
    output logic [WIDTH-1:0]                  o_r_data,
    output logic [WIDTH-1:0]                  o_g_data,
    output logic [WIDTH-1:0]                  o_b_data,
    output logic [$clog2(H_RES*V_RES+1)-1:0]  o_edge_count,
    output logic                              o_count_valid
);

    localparam int CW = $clog2(H_RES*V_RES+1);
    localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;
    localparam logic [XW-1:0] X_MAX = XW'(H_RES-1);
    localparam logic [YW-1:0] Y_MAX = YW'(V_RES-1);
    localparam logic [CW-1:0] C_MAX = CW'(H_RES*V_RES);

    logic             vs_q, de_q;
    logic [XW-1:0]    x_q, x_d;
    logic [YW-1:0]    y_q, y_d;
    logic [WIDTH-1:0] thr_q, thr_d;
    logic             inv_q, inv_d;

    logic [WIDTH-1:0] s1_gray_q, s1_gray_d;
    logic             s1_bord_q, s1_bord_d;
    logic             s1_de_q, s1_hs_q, s1_vs_q;

    logic             s2_edge_q, s2_edge_d;
    logic             s2_de_q, s2_hs_q, s2_vs_q;
    logic [WIDTH-1:0] pix_q, pix_d;

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CW-1:0]    ecnt_q, ecnt_d;
    logic             cval_q;

    logic             frame_start, de_fall, hit;
    logic [WIDTH+1:0] sum;

    assign frame_start = i_vsync & ~vs_q;
    assign de_fall     = de_q & ~i_de;
    assign hit         = s2_de_q & s2_edge_q;

    always_comb begin
        x_d       = x_q;
        y_d       = y_q;
        thr_d     = thr_q;
        inv_d     = inv_q;
        cnt_d     = cnt_q;
        ecnt_d    = ecnt_q;
        sum       = {2'b00, i_r_data} + {1'b0, i_g_data, 1'b0}
                  + {2'b00, i_b_data};
        s1_gray_d = sum[WIDTH+1:2];
        s1_bord_d = (int'(x_q) < BORDER) || (int'(y_q) < BORDER);
        s2_edge_d = (s1_gray_q >= thr_q) && !s1_bord_q;
        pix_d     = (s1_de_q && (s2_edge_d ^ inv_q)) ? '1 : '0;

        if (de_fall) begin
            x_d = '0;
        end else if (i_de && x_q != X_MAX) begin
            x_d = x_q + 1'b1;
        end

        // frame start clears the row even if a line ends on the same clock
        if (frame_start) begin
            y_d = '0;
        end else if (de_fall && y_q != Y_MAX) begin
            y_d = y_q + 1'b1;
        end

        if (frame_start) begin
            thr_d  = i_thresh;
            inv_d  = i_invert;
            ecnt_d = cnt_q;
            cnt_d  = hit ? CW'(1) : '0;
        end else if (hit && cnt_q != C_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vs_q      <= 1'b0;
            de_q      <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            thr_q     <= '0;
            inv_q     <= 1'b0;
            s1_gray_q <= '0;
            s1_bord_q <= 1'b0;
            s1_de_q   <= 1'b0;
            s1_hs_q   <= 1'b0;
            s1_vs_q   <= 1'b0;
            s2_edge_q <= 1'b0;
            s2_de_q   <= 1'b0;
            s2_hs_q   <= 1'b0;
            s2_vs_q   <= 1'b0;
            pix_q     <= '0;
            cnt_q     <= '0;
            ecnt_q    <= '0;
            cval_q    <= 1'b0;
        end else begin
            vs_q      <= i_vsync;
            de_q      <= i_de;
            x_q       <= x_d;
            y_q       <= y_d;
            thr_q     <= thr_d;
            inv_q     <= inv_d;
            s1_gray_q <= s1_gray_d;
            s1_bord_q <= s1_bord_d;
            s1_de_q   <= i_de;
            s1_hs_q   <= i_hsync;
            s1_vs_q   <= i_vsync;
            s2_edge_q <= s2_edge_d;
            s2_de_q   <= s1_de_q;
            s2_hs_q   <= s1_hs_q;
            s2_vs_q   <= s1_vs_q;
            pix_q     <= pix_d;
            cnt_q     <= cnt_d;
            ecnt_q    <= ecnt_d;
            cval_q    <= frame_start;
        end
    end

    assign o_vsync       = s2_vs_q;
    assign o_hsync       = s2_hs_q;
    assign o_de          = s2_de_q;
    assign o_r_data      = pix_q;
    assign o_g_data      = pix_q;
    assign o_b_data      = pix_q;
    assign o_edge_count  = ecnt_q;
    assign o_count_valid = cval_q;

endmodule

// File: tb/tb_edge_binarize.sv
// Scoreboard bench for edge_binarize on a small 16x8 raster.
module tb_edge_binarize;

    localparam int W  = 8;
    localparam int H  = 16;
    localparam int V  = 8;
    localparam int B  = 2;
    localparam int CW = $clog2(H*V+1);

    typedef struct packed {
        logic         vs;
        logic         hs;
        logic         de;
        logic [W-1:0] d;
    } ent_t;

    logic          clk = 1'b0;
    logic          rstn;
    logic          i_vsync, i_hsync, i_de, i_invert;
    logic [W-1:0]  i_r_data, i_g_data, i_b_data, i_thresh;
    logic          o_vsync, o_hsync, o_de, o_count_valid;
    logic [W-1:0]  o_r_data, o_g_data, o_b_data;
    logic [CW-1:0] o_edge_count;

    ent_t q[$];
    int   cq[$];
    int   errors = 0;
    int   checks = 0;
    int   ecount = 0;
    int   thr_f  = 0;
    int   inv_f  = 0;
    logic vs_prev = 1'b0;
    ent_t me, got;
    int   ce;

    always #5 clk = ~clk;

    edge_binarize #(
        .WIDTH(W), .H_RES(H), .V_RES(V), .BORDER(B)
    ) dut (
        .clk(clk), .rstn(rstn),
        .i_vsync(i_vsync), .i_hsync(i_hsync), .i_de(i_de),
        .i_r_data(i_r_data), .i_g_data(i_g_data), .i_b_data(i_b_data),
        .i_thresh(i_thresh), .i_invert(i_invert),
        .o_vsync(o_vsync), .o_hsync(o_hsync), .o_de(o_de),
        .o_r_data(o_r_data), .o_g_data(o_g_data), .o_b_data(o_b_data),
        .o_edge_count(o_edge_count), .o_count_valid(o_count_valid)
    );

    always @(negedge clk) begin
        if (rstn) begin
            if (q.size() >= 3) begin
                me  = q.pop_front();
                got = {o_vsync, o_hsync, o_de, o_r_data};
                checks++;
                assert (got === me && o_g_data === me.d
                        && o_b_data === me.d)
                else begin
                    errors++;
                    $error("FAIL pipe got=%h g=%h b=%h exp=%h",
                           got, o_g_data, o_b_data, me);
                end
            end
            if (o_count_valid) begin
                checks++;
                ce = (cq.size() > 0) ? cq.pop_front() : -1;
                assert (ce >= 0 && int'(o_edge_count) == ce)
                else begin
                    errors++;
                    $error("FAIL count got=%0d exp=%0d", o_edge_count, ce);
                end
            end
        end
    end

    function automatic logic [3*W-1:0] pix(input int mode, input int x);
        logic [W-1:0] v;
        case (mode)
            0: pix = {3{8'd255}};
            1: pix = {W'($urandom_range(0, 255)), W'($urandom_range(0, 255)),
                      W'($urandom_range(0, 255))};
            2: pix = {8'd0, 8'd255, 8'd0};
            default: begin
                v   = (x % 2 == 1) ? 8'd100 : 8'd99;
                pix = {v, v, v};
            end
        endcase
    endfunction

    task automatic tick(input logic vs, input logic hs, input logic de,
                        input logic [3*W-1:0] rgb, input int x, input int y);
        ent_t e;
        int   gray;
        bit   edg;
        @(posedge clk);
        #1;
        i_vsync  = vs;
        i_hsync  = hs;
        i_de     = de;
        {i_r_data, i_g_data, i_b_data} = rgb;
        if (rstn) begin
            if (vs && !vs_prev) begin
                cq.push_back(ecount);
                ecount = 0;
                thr_f  = int'(i_thresh);
                inv_f  = int'(i_invert);
            end
            gray = (int'(rgb[23:16]) + 2*int'(rgb[15:8])
                    + int'(rgb[7:0])) / 4;
            edg  = de && gray >= thr_f && x >= B && y >= B;
            if (edg) ecount++;
            e.vs = vs;
            e.hs = hs;
            e.de = de;
            e.d  = (de && (edg ^ (inv_f != 0))) ? '1 : '0;
            q.push_back(e);
        end
        vs_prev = vs;
    endtask

    task automatic line(input int y, input int mode);
        for (int x = 0; x < H; x++) tick(0, 0, 1, pix(mode, x), x, y);
        tick(0, 1, 0, '0, 0, 0);
        tick(0, 0, 0, '0, 0, 0);
        tick(0, 0, 0, '0, 0, 0);
    endtask

    task automatic vstart(input int thr, input bit inv);
        i_thresh = W'(thr);
        i_invert = inv;
        tick(1, 0, 0, '0, 0, 0);
        tick(1, 0, 0, '0, 0, 0);
        tick(0, 0, 0, '0, 0, 0);
        tick(0, 0, 0, '0, 0, 0);
    endtask

    task automatic frame(input int mode, input int thr, input bit inv,
                         input int thr_mid);
        vstart(thr, inv);
        for (int y = 0; y < V; y++) begin
            if (y == V/2) i_thresh = W'(thr_mid);
            line(y, mode);
        end
    endtask

    task automatic chk0(input string tag, input logic [CW-1:0] v);
        checks++;
        assert (v === '0)
        else begin
            errors++;
            $error("FAIL %s got=%h exp=0", tag, v);
        end
    endtask

    task automatic chk_zero_outs(input string tag);
        chk0({tag, "_de"}, CW'(o_de));
        chk0({tag, "_sync"}, CW'({o_vsync, o_hsync}));
        chk0({tag, "_data"}, CW'(o_r_data | o_g_data | o_b_data));
        chk0({tag, "_cval"}, CW'(o_count_valid));
        chk0({tag, "_cnt"}, o_edge_count);
    endtask

    initial begin
        rstn = 1'b0;
        {i_vsync, i_hsync, i_de, i_invert} = '0;
        {i_r_data, i_g_data, i_b_data, i_thresh} = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero_outs("rst");
        rstn = 1'b1;

        frame(1, 100, 0, 200);
        frame(1, 200, 0, 200);
        frame(3, 100, 0, 100);
        frame(0, 0, 0, 0);
        frame(0, 0, 1, 0);
        frame(2, 127, 0, 127);
        frame(2, 128, 0, 128);
        frame(0, 255, 0, 255);
        frame(1, 80, 1, 80);

        vstart(50, 0);
        for (int y = 0; y < 3; y++) line(y, 1);
        for (int x = 0; x < 6; x++) tick(0, 0, 1, pix(0, x), x, 3);
        rstn = 1'b0;
        #1;
        chk_zero_outs("midrst");
        q.delete();
        ecount  = 0;
        thr_f   = 0;
        inv_f   = 0;
        vs_prev = 1'b0;
        i_de    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        for (int y = 0; y < 3; y++) line(y, 0);

        frame(1, 60, 0, 60);
        tick(1, 0, 0, '0, 0, 0);
        repeat (6) tick(0, 0, 0, '0, 0, 0);

        checks++;
        assert (cq.size() == 0)
        else begin
            errors++;
            $error("FAIL count_pending got=%0d exp=0", cq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
